// File: rtl/ball_score_unit.sv
// Ball motion, paddle/wall collision and goal scoring for the game controller.
// Advances the ball only in PLAY, once every TICK_DIV clock cycles.
module ball_score_unit #(
    parameter int SCREEN_W     = 640,
    parameter int SCREEN_H     = 480,
    parameter int BALL_SIZE    = 8,
    parameter int PADDLE_W     = 8,
    parameter int PADDLE_H     = 64,
    parameter int PADDLE_X_ESQ = 16,
    parameter int PADDLE_X_DIR = 616,
    parameter int STEP         = 2,
    parameter int TICK_DIV     = 100000,
    parameter int WIN          = 5
) (
    input  logic       clk,
    input  logic       sim_rst,
    input  logic [1:0] game_state,
    input  logic [9:0] paddle_esq_y,
    input  logic [9:0] paddle_dir_y,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic       col_esquerda,
    output logic       col_direita,
    output logic [3:0] score_esquerda,
    output logic [3:0] score_direita
);

    typedef enum logic [1:0] {
        NEW_GAME = 2'b00,
        READY    = 2'b01,
        PLAY     = 2'b10,
        END_GAME = 2'b11
    } state_t;

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [9:0] X_CENTER = 10'((SCREEN_W - BALL_SIZE) / 2);
    localparam logic [9:0] Y_CENTER = 10'((SCREEN_H - BALL_SIZE) / 2);
    localparam logic [9:0] X_MAX    = 10'(SCREEN_W - BALL_SIZE);
    localparam logic [9:0] Y_MAX    = 10'(SCREEN_H - BALL_SIZE);
    localparam logic [9:0] FACE_L   = 10'(PADDLE_X_ESQ + PADDLE_W);
    localparam logic [9:0] FACE_R   = 10'(PADDLE_X_DIR - BALL_SIZE);

    // Signed copies so that stepping past an edge yields a comparable value, never a wrap.
    localparam logic signed [11:0] STEP_S   = 12'(STEP);
    localparam logic signed [11:0] BALL_S   = 12'(BALL_SIZE);
    localparam logic signed [11:0] PADH_S   = 12'(PADDLE_H);
    localparam logic signed [11:0] X_MAX_S  = 12'(SCREEN_W - BALL_SIZE);
    localparam logic signed [11:0] Y_MAX_S  = 12'(SCREEN_H - BALL_SIZE);
    localparam logic signed [11:0] FACE_L_S = 12'(PADDLE_X_ESQ + PADDLE_W);
    localparam logic signed [11:0] FACE_R_S = 12'(PADDLE_X_DIR - BALL_SIZE);

    function automatic logic [3:0] sat_inc(input logic [3:0] s);
        return (s >= 4'(WIN)) ? 4'(WIN) : s + 4'd1;
    endfunction

    function automatic logic signed [11:0] to_s(input logic [9:0] v);
        return signed'({2'b00, v});
    endfunction

    logic          dx_pos, dy_pos;
    logic          goal_latch;
    logic [PW-1:0] presc;
    logic          tick;

    logic signed [11:0] x_s, y_s, pe_s, pd_s, nx, ny;
    logic               ovl_esq, ovl_dir;
    logic [9:0]         x_next, y_next;
    logic               dx_next, dy_next;
    logic               goal_esq, goal_dir;

    assign tick = (presc == PW'(TICK_DIV - 1));

    always_comb begin
        x_s  = to_s(ball_x);
        y_s  = to_s(ball_y);
        pe_s = to_s(paddle_esq_y);
        pd_s = to_s(paddle_dir_y);

        ny      = dy_pos ? (y_s + STEP_S) : (y_s - STEP_S);
        y_next  = ny[9:0];
        dy_next = dy_pos;
        if (ny <= 12'sd0) begin
            y_next  = '0;
            dy_next = 1'b1;
        end else if (ny >= Y_MAX_S) begin
            y_next  = Y_MAX;
            dy_next = 1'b0;
        end

        // Overlap uses the pre-move y, so a paddle hit is judged where the ball was.
        ovl_esq = (y_s < pe_s + PADH_S) && (y_s + BALL_S > pe_s);
        ovl_dir = (y_s < pd_s + PADH_S) && (y_s + BALL_S > pd_s);

        goal_esq = 1'b0;
        goal_dir = 1'b0;
        dx_next  = dx_pos;
        if (!dx_pos) begin
            nx     = x_s - STEP_S;
            x_next = nx[9:0];
            if (nx <= FACE_L_S && x_s >= FACE_L_S && ovl_esq) begin
                x_next  = FACE_L;
                dx_next = 1'b1;
            end else if (nx <= 12'sd0) begin
                x_next   = '0;
                goal_esq = 1'b1;
                dx_next  = 1'b1;
            end
        end else begin
            nx     = x_s + STEP_S;
            x_next = nx[9:0];
            if (nx >= FACE_R_S && x_s <= FACE_R_S && ovl_dir) begin
                x_next  = FACE_R;
                dx_next = 1'b0;
            end else if (nx >= X_MAX_S) begin
                x_next   = X_MAX;
                goal_dir = 1'b1;
                dx_next  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (sim_rst) begin
            ball_x         <= X_CENTER;
            ball_y         <= Y_CENTER;
            dx_pos         <= 1'b1;
            dy_pos         <= 1'b1;
            col_esquerda   <= 1'b0;
            col_direita    <= 1'b0;
            score_esquerda <= '0;
            score_direita  <= '0;
            presc          <= '0;
            goal_latch     <= 1'b0;
        end else begin
            col_esquerda <= 1'b0;
            col_direita  <= 1'b0;
            case (state_t'(game_state))
                NEW_GAME: begin
                    ball_x         <= X_CENTER;
                    ball_y         <= Y_CENTER;
                    dx_pos         <= 1'b1;
                    dy_pos         <= 1'b1;
                    score_esquerda <= '0;
                    score_direita  <= '0;
                    presc          <= '0;
                    goal_latch     <= 1'b0;
                end
                READY: begin
                    ball_x     <= X_CENTER;
                    ball_y     <= Y_CENTER;
                    presc      <= '0;
                    goal_latch <= 1'b0;
                end
                PLAY: begin
                    presc <= tick ? '0 : presc + 1'b1;
                    // After a goal the ball stays put until the FSM leaves PLAY.
                    if (tick && !goal_latch) begin
                        ball_x       <= x_next;
                        ball_y       <= y_next;
                        dx_pos       <= dx_next;
                        dy_pos       <= dy_next;
                        col_esquerda <= goal_esq;
                        col_direita  <= goal_dir;
                        goal_latch   <= goal_esq | goal_dir;
                        if (goal_esq) score_direita  <= sat_inc(score_direita);
                        if (goal_dir) score_esquerda <= sat_inc(score_esquerda);
                    end
                end
                default: begin
                    presc <= '0;
                end
            endcase
        end
    end

endmodule
